alu_arbiter: RTL and testbench

//   Shares one combinational ALU (SrcA/SrcB/ALUControl -> ALUResult/ALUFlags)

---
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU among NREQ requesters.
// Each operation runs IDLE (grant) -> EXEC (ALU evaluates) -> RESP (result held until taken).
module alu_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_srca,
  input  logic [NREQ*WIDTH-1:0] req_srcb,
  input  logic [NREQ*2-1:0]     req_ctrl,
  output logic [WIDTH-1:0]      alu_srca,
  output logic [WIDTH-1:0]      alu_srcb,
  output logic [1:0]            alu_ctrl,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic [3:0]            alu_flags,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [3:0]            rsp_flags,
  input  logic                  rsp_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IDW-1:0]      r_last;
  logic [IDW-1:0]      w_grant;
  logic                w_grant_vld;
  logic                w_accept;

  logic [WIDTH-1:0]    r_op_a;
  logic [WIDTH-1:0]    r_op_b;
  logic [1:0]          r_op_ctrl;
  logic [IDW-1:0]      r_op_id;

  logic                r_rsp_valid;
  logic [IDW-1:0]      r_rsp_id;
  logic [WIDTH-1:0]    r_rsp_result;
  logic [3:0]          r_rsp_flags;

  // Scan from farthest to nearest so the nearest requester after r_last wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(r_last) + k) % NREQ]) begin
        w_grant_vld = 1'b1;
        w_grant     = IDW'((int'(r_last) + k) % NREQ);
      end
    end
  end

  assign w_accept  = reset_n && (r_state == S_IDLE) && w_grant_vld;
  assign req_ready = w_accept ? (NREQ'(1) << w_grant) : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_vld) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (r_rsp_valid && rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last       <= IDW'(NREQ - 1);
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_ctrl    <= '0;
      r_op_id      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op_a    <= req_srca[w_grant*WIDTH +: WIDTH];
        r_op_b    <= req_srcb[w_grant*WIDTH +: WIDTH];
        r_op_ctrl <= req_ctrl[w_grant*2 +: 2];
        r_op_id   <= w_grant;
        r_last    <= w_grant;
      end
      // ALU sees stable registered operands for all of EXEC; capture its outputs verbatim.
      if (r_state == S_EXEC) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_id     <= r_op_id;
        r_rsp_result <= alu_result;
        r_rsp_flags  <= alu_flags;
      end else if ((r_state == S_RESP) && r_rsp_valid && rsp_ready) begin
        r_rsp_valid  <= 1'b0;
      end
    end
  end

  assign alu_srca   = r_op_a;
  assign alu_srcb   = r_op_b;
  assign alu_ctrl   = r_op_ctrl;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU plus a transaction-level model checked
// every cycle, and directed scenarios with hand-computed literal expectations.
module tb_alu_arbiter;
  localparam int NREQ  = 2;
  localparam int WIDTH = 32;
  localparam int IDW   = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_srca;
  logic [NREQ*WIDTH-1:0] req_srcb;
  logic [NREQ*2-1:0]     req_ctrl;
  logic [WIDTH-1:0]      alu_srca, alu_srcb, alu_result;
  logic [1:0]            alu_ctrl;
  logic [3:0]            alu_flags;
  logic                  rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic [3:0]            rsp_flags;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_srca(req_srca), .req_srcb(req_srcb), .req_ctrl(req_ctrl),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_ready(rsp_ready), .busy(busy)
  );

  // Reference ALU: result followed by flags {N,Z,C,V}; C on subtract means no borrow.
  function automatic logic [WIDTH+3:0] alu_ref(input logic [WIDTH-1:0] a, b, input logic [1:0] c);
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] r;
    logic             cy, v;
    wide = '0; r = '0; cy = 1'b0; v = 1'b0;
    case (c)
      2'b00: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[WIDTH-1:0];
        cy   = wide[WIDTH];
        v    = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      2'b01: begin
        r  = a - b;
        cy = (a >= b);
        v  = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r, r[WIDTH-1], (r == '0), cy, v};
  endfunction

  assign {alu_result, alu_flags} = alu_ref(alu_srca, alu_srcb, alu_ctrl);

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // Transaction model: at most one op outstanding; response visible from two cycles after accept.
  int               cyc = 0;
  int               m_acc = 0;
  int               m_last = NREQ - 1;
  bit               m_busy = 1'b0;
  int               m_pick;
  int               m_pk;
  logic [IDW-1:0]   m_id = '0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [1:0]       m_c = '0;
  logic [3:0]       m_flg = '0;
  logic             exp_rv;
  logic [NREQ-1:0]  exp_rr;

  always_comb begin
    m_pick = pick(req_valid, m_last);
    m_pk   = (m_pick < 0) ? 0 : m_pick;
    exp_rv = m_busy && (cyc >= m_acc + 2);
    exp_rr = (!m_busy && m_pick >= 0) ? (NREQ'(1) << m_pk) : '0;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_last <= NREQ - 1;
    end else begin
      cyc <= cyc + 1;
      if (!m_busy) begin
        if (m_pick >= 0) begin
          m_busy <= 1'b1;
          m_acc  <= cyc;
          m_last <= m_pick;
          m_id   <= IDW'(m_pk);
          m_a    <= req_srca[m_pk*WIDTH +: WIDTH];
          m_b    <= req_srcb[m_pk*WIDTH +: WIDTH];
          m_c    <= req_ctrl[m_pk*2 +: 2];
          {m_res, m_flg} <= alu_ref(req_srca[m_pk*WIDTH +: WIDTH], req_srcb[m_pk*WIDTH +: WIDTH],
                                    req_ctrl[m_pk*2 +: 2]);
        end
      end else if (exp_rv && rsp_ready) begin
        m_busy <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("req_ready", 64'(req_ready), 64'(exp_rr));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv) begin
        chk("rsp_id", 64'(rsp_id), 64'(m_id));
        chk("rsp_result", 64'(rsp_result), 64'(m_res));
        chk("rsp_flags", 64'(rsp_flags), 64'(m_flg));
      end
      if (m_busy) begin
        chk("alu_srca", 64'(alu_srca), 64'(m_a));
        chk("alu_srcb", 64'(alu_srcb), 64'(m_b));
        chk("alu_ctrl", 64'(alu_ctrl), 64'(m_c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, b, input logic [1:0] c, input logic v);
    req_srca[i*WIDTH +: WIDTH] = a;
    req_srcb[i*WIDTH +: WIDTH] = b;
    req_ctrl[i*2 +: 2]         = c;
    req_valid[i]               = v;
  endtask

  int gcyc[4];
  int gid[4];
  int ng;
  logic [WIDTH-1:0] rres[2];
  int nr;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; req_valid = '0; req_srca = '0; req_srcb = '0; req_ctrl = '0; rsp_ready = 1'b1;
    #12;
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset alu_srca", 64'(alu_srca), 64'd0);
    chk("reset rsp_result", 64'(rsp_result), 64'd0);
    tick();
    reset_n = 1'b1;

    // 1: requester 0 alone, 2 - 1
    set_req(0, 32'd2, 32'd1, 2'b01, 1'b1);
    #1 chk("t1 req_ready", 64'(req_ready), 64'b01);
    tick(); req_valid[0] = 1'b0;
    chk("t1 busy", 64'(busy), 64'd1);
    chk("t1 no early rsp", 64'(rsp_valid), 64'd0);
    tick();
    chk("t1 rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1 rsp_id", 64'(rsp_id), 64'd0);
    chk("t1 result", 64'(rsp_result), 64'd1);
    chk("t1 flags", 64'(rsp_flags), 64'b0010);
    tick();
    chk("t1 rsp dropped", 64'(rsp_valid), 64'd0);

    // 2: requester 1 alone, 3 - 5
    set_req(1, 32'd3, 32'd5, 2'b01, 1'b1);
    #1 chk("t2 req_ready", 64'(req_ready), 64'b10);
    tick(); req_valid[1] = 1'b0;
    tick();
    chk("t2 rsp_id", 64'(rsp_id), 64'd1);
    chk("t2 result", 64'(rsp_result), 64'hFFFF_FFFE);
    chk("t2 flags", 64'(rsp_flags), 64'b1000);
    tick();

    // 3: both continuously valid from reset
    reset_n = 1'b0; #2 reset_n = 1'b1;
    set_req(0, 32'd10, 32'd1, 2'b00, 1'b1);
    set_req(1, 32'd20, 32'd2, 2'b01, 1'b1);
    #1;
    ng = 0; nr = 0;
    for (int s = 0; s < 20; s++) begin
      if (rsp_valid && nr < 2) begin rres[nr] = rsp_result; nr++; end
      if (req_ready != '0) begin
        gcyc[ng] = s;
        gid[ng]  = (req_ready == 2'b10) ? 1 : 0;
        ng++;
      end
      if (ng == 4) break;
      tick();
    end
    tick(); req_valid = '0;
    chk("t3 grant count", 64'(ng), 64'd4);
    if (ng == 4) begin
      chk("t3 grant0", 64'(gid[0]), 64'd0);
      chk("t3 grant1", 64'(gid[1]), 64'd1);
      chk("t3 grant2", 64'(gid[2]), 64'd0);
      chk("t3 grant3", 64'(gid[3]), 64'd1);
      for (int k = 0; k < 3; k++)
        chk("t3 spacing", 64'(gcyc[k+1] - gcyc[k]), 64'd3);
    end
    chk("t3 rsp count", 64'(nr), 64'd2);
    if (nr == 2) begin
      chk("t3 rsp0", 64'(rres[0]), 64'd11);
      chk("t3 rsp1", 64'(rres[1]), 64'd18);
    end
    repeat (3) tick();

    // 4: backpressure on the response, 5 AND 3
    set_req(0, 32'd5, 32'd3, 2'b10, 1'b1);
    #1 chk("t4 req_ready", 64'(req_ready), 64'b01);
    tick(); req_valid[0] = 1'b0; rsp_ready = 1'b0;
    tick();
    set_req(1, 32'd9, 32'd9, 2'b00, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4 hold valid", 64'(rsp_valid), 64'd1);
      chk("t4 hold result", 64'(rsp_result), 64'd1);
      chk("t4 no ready", 64'(req_ready), 64'd0);
      chk("t4 busy", 64'(busy), 64'd1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("t4 next grant", 64'(req_ready), 64'b10);
    tick(); req_valid[1] = 1'b0;
    repeat (3) tick();

    // 5: reset during EXEC of 7 + 8
    set_req(0, 32'd7, 32'd8, 2'b00, 1'b1);
    #1 chk("t5 req_ready", 64'(req_ready), 64'b01);
    tick(); req_valid[0] = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("t5 alu_srca", 64'(alu_srca), 64'd0);
    chk("t5 alu_srcb", 64'(alu_srcb), 64'd0);
    chk("t5 alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("t5 busy", 64'(busy), 64'd0);
    chk("t5 rsp_valid", 64'(rsp_valid), 64'd0);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5 no rsp", 64'(rsp_valid), 64'd0);
    end
    set_req(0, 32'd1, 32'd1, 2'b00, 1'b1);
    set_req(1, 32'd2, 32'd2, 2'b00, 1'b1);
    #1 chk("t5 grant after reset", 64'(req_ready), 64'b01);
    tick(); req_valid = '0;
    repeat (3) tick();

    // 6: requester 0 withdraws before the arbiter returns to IDLE
    set_req(1, 32'd1, 32'd1, 2'b11, 1'b1);
    tick(); req_valid[1] = 1'b0;
    set_req(0, 32'd4, 32'd4, 2'b00, 1'b1);
    #1 chk("t6 exec no ready", 64'(req_ready), 64'd0);
    tick(); req_valid[0] = 1'b0;
    #1 chk("t6 resp no ready", 64'(req_ready), 64'd0);
    tick();
    chk("t6 idle no ready", 64'(req_ready), 64'd0);
    chk("t6 idle busy", 64'(busy), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6 busy low", 64'(busy), 64'd0);
      chk("t6 no rsp", 64'(rsp_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
